// File: rtl/ex_mem_div_if.sv
// EX/MEM boundary bundle: EX-side instruction, divider result path, MEM-side register
// and divide-control status. The slave modport is the pipe register's view.
interface ex_mem_div_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 8
);
  // Handshake: an instruction moves EX->MEM on a cycle where ex_valid and the
  // internal ready_go are both high and mem_allowin is high; ex_allowin tells ID it may refill EX.
  logic            ex_valid;
  logic [OP_W-1:0] ex_op;
  logic            ex_is_div;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_alu_result;
  logic [4:0]      ex_dest;
  logic            ex_rf_we;
  logic            div_out_valid;
  logic [XLEN-1:0] div_out;
  logic            mem_allowin;
  logic            flush;
  logic [OP_W-1:0] div_op;
  logic            ex_allowin;
  logic            mem_valid;
  logic [XLEN-1:0] mem_pc;
  logic [XLEN-1:0] mem_result;
  logic [4:0]      mem_dest;
  logic            mem_rf_we;
  logic [OP_W-1:0] mem_op;
  logic            div_busy;
  logic            div_timeout;
  logic [1:0]      div_state;

  modport master (
    output ex_valid, ex_op, ex_is_div, ex_pc, ex_alu_result, ex_dest, ex_rf_we,
           div_out_valid, div_out, mem_allowin, flush,
    input  div_op, ex_allowin, mem_valid, mem_pc, mem_result, mem_dest, mem_rf_we,
           mem_op, div_busy, div_timeout, div_state
  );

  modport slave (
    input  ex_valid, ex_op, ex_is_div, ex_pc, ex_alu_result, ex_dest, ex_rf_we,
           div_out_valid, div_out, mem_allowin, flush,
    output div_op, ex_allowin, mem_valid, mem_pc, mem_result, mem_dest, mem_rf_we,
           mem_op, div_busy, div_timeout, div_state
  );
endinterface

// File: rtl/ex_mem_div_pipe.sv
// EX->MEM pipeline register that stalls EX across a multi-cycle divide, issues the divider
// op once per instruction, holds an unaccepted result and drains a divide orphaned by flush.
module ex_mem_div_pipe #(
  parameter int XLEN       = 32,
  parameter int OP_W       = 8,
  parameter int TMO_CYCLES = 63
) (
  input logic         clk,
  input logic         rst,
  ex_mem_div_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(TMO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TMO_CYCLES);

  state_t          state;
  logic [XLEN-1:0] hold_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic            ex_ready_go;
  logic            ex_to_mem;
  logic [XLEN-1:0] result_sel;

  // A div completes only on the pulse cycle in WAIT or from the hold in DONE; DRAIN blocks divs.
  assign ex_ready_go = !bus.ex_is_div || (state == DONE) ||
                       ((state == WAIT) && bus.div_out_valid);
  assign ex_to_mem   = bus.ex_valid && ex_ready_go && !bus.flush;
  assign bus.ex_allowin = !bus.ex_valid || (ex_ready_go && bus.mem_allowin);

  // The divider only sees the op while it is computing this instruction.
  assign bus.div_op = (bus.ex_valid && bus.ex_is_div && !bus.flush &&
                       ((state == IDLE) || (state == WAIT))) ? bus.ex_op : '0;

  assign cnt_inc = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;

  always_comb begin
    result_sel = bus.ex_alu_result;
    if (bus.ex_is_div) begin
      if (state == WAIT)      result_sel = bus.div_out;
      else if (state == DONE) result_sel = hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.div_busy    <= 1'b0;
      bus.div_timeout <= 1'b0;
      tmo_cnt         <= '0;
      hold_q          <= '0;
    end else begin
      if (tmo_cnt == TMO_MAX) bus.div_timeout <= 1'b1;
      if (bus.flush) begin
        // An in-flight divide still owes a pulse, so it must be drained.
        if ((state == WAIT) || (state == DRAIN)) begin
          state        <= DRAIN;
          bus.div_busy <= 1'b1;
          tmo_cnt      <= cnt_inc;
        end else begin
          state        <= IDLE;
          bus.div_busy <= 1'b0;
          tmo_cnt      <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (bus.ex_valid && bus.ex_is_div) begin
              state        <= WAIT;
              bus.div_busy <= 1'b1;
            end
          end
          WAIT: begin
            if (bus.div_out_valid) begin
              tmo_cnt <= '0;
              if (bus.mem_allowin) begin
                state        <= IDLE;
                bus.div_busy <= 1'b0;
              end else begin
                state  <= DONE;
                hold_q <= bus.div_out;
              end
            end else begin
              tmo_cnt <= cnt_inc;
            end
          end
          DONE: begin
            if (bus.mem_allowin) begin
              state        <= IDLE;
              bus.div_busy <= 1'b0;
            end
          end
          DRAIN: begin
            if (bus.div_out_valid) begin
              state        <= IDLE;
              bus.div_busy <= 1'b0;
              tmo_cnt      <= '0;
            end else begin
              tmo_cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_valid  <= 1'b0;
      bus.mem_pc     <= '0;
      bus.mem_result <= '0;
      bus.mem_dest   <= '0;
      bus.mem_rf_we  <= 1'b0;
      bus.mem_op     <= '0;
    end else if (bus.flush) begin
      bus.mem_valid <= 1'b0;
    end else if (bus.mem_allowin) begin
      bus.mem_valid <= ex_to_mem;
      if (ex_to_mem) begin
        bus.mem_pc     <= bus.ex_pc;
        bus.mem_result <= result_sel;
        bus.mem_dest   <= bus.ex_dest;
        bus.mem_rf_we  <= bus.ex_rf_we;
        bus.mem_op     <= bus.ex_op;
      end
    end
  end

  assign bus.div_state = state;
endmodule

// File: tb/tb_ex_mem_div_pipe.sv
// Directed bench for ex_mem_div_pipe: ALU pass-through, divide stall/hold/drain,
// back-to-back divides, mid-divide reset and the sticky timeout.
module tb_ex_mem_div_pipe;
  localparam int XLEN = 32;
  localparam int OP_W = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2, S_DRAIN = 2'd3;
  localparam logic [OP_W-1:0] OP_ADD = 8'h01, OP_DIV = 8'h20, OP_DIVU = 8'h22;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ex_mem_div_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

  ex_mem_div_pipe #(.XLEN(XLEN), .OP_W(OP_W), .TMO_CYCLES(63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.ex_valid      = 1'b0;
    bus.ex_op         = '0;
    bus.ex_is_div     = 1'b0;
    bus.ex_pc         = '0;
    bus.ex_alu_result = '0;
    bus.ex_dest       = '0;
    bus.ex_rf_we      = 1'b0;
    bus.div_out_valid = 1'b0;
    bus.div_out       = '0;
    bus.mem_allowin   = 1'b1;
    bus.flush         = 1'b0;
  endtask

  task automatic drive_ex(input logic [OP_W-1:0] op, input logic is_div,
                          input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu,
                          input logic [4:0] dest);
    bus.ex_valid      = 1'b1;
    bus.ex_op         = op;
    bus.ex_is_div     = is_div;
    bus.ex_pc         = pc;
    bus.ex_alu_result = alu;
    bus.ex_dest       = dest;
    bus.ex_rf_we      = 1'b1;
  endtask

  task automatic settle();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%0h exp=0", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'h0) begin failures++; $display("FAIL reset_mem_result got=%0h exp=0", bus.mem_result); end
    checks++; if (bus.div_busy !== 1'b0) begin failures++; $display("FAIL reset_div_busy got=%0h exp=0", bus.div_busy); end
    checks++; if (bus.div_timeout !== 1'b0) begin failures++; $display("FAIL reset_div_timeout got=%0h exp=0", bus.div_timeout); end
    checks++; if (bus.div_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0h exp=%0h", bus.div_state, S_IDLE); end
  endtask

  task automatic test_alu_pass();
    settle();
    drive_ex(OP_ADD, 1'b0, 32'h100, 32'h1234, 5'd3);
    #1;
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL add_allowin got=%0h exp=1", bus.ex_allowin); end
    checks++; if (bus.div_op !== 8'h00) begin failures++; $display("FAIL add_div_op got=%0h exp=0", bus.div_op); end
    tick();
    bus.ex_valid = 1'b0;
    checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL add_mem_valid got=%0h exp=1", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'h1234) begin failures++; $display("FAIL add_mem_result got=%0h exp=1234", bus.mem_result); end
    checks++; if (bus.mem_pc !== 32'h100) begin failures++; $display("FAIL add_mem_pc got=%0h exp=100", bus.mem_pc); end
    checks++; if (bus.mem_dest !== 5'd3) begin failures++; $display("FAIL add_mem_dest got=%0h exp=3", bus.mem_dest); end
    tick();
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL add_drop_valid got=%0h exp=0", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'h1234) begin failures++; $display("FAIL add_hold_result got=%0h exp=1234", bus.mem_result); end
  endtask

  task automatic test_div_stall();
    settle();
    drive_ex(OP_DIV, 1'b1, 32'h200, 32'h9999, 5'd5);
    #1;
    checks++; if (bus.div_op !== OP_DIV) begin failures++; $display("FAIL div_issue_op got=%0h exp=%0h", bus.div_op, OP_DIV); end
    checks++; if (bus.ex_allowin !== 1'b0) begin failures++; $display("FAIL div_issue_allowin got=%0h exp=0", bus.ex_allowin); end
    tick();
    checks++; if (bus.div_state !== S_WAIT) begin failures++; $display("FAIL div_state_wait got=%0h exp=%0h", bus.div_state, S_WAIT); end
    checks++; if (bus.div_busy !== 1'b1) begin failures++; $display("FAIL div_busy got=%0h exp=1", bus.div_busy); end
    for (int i = 1; i < 10; i++) begin
      checks++; if (bus.ex_allowin !== 1'b0) begin failures++; $display("FAIL div_wait_allowin cyc=%0d got=%0h exp=0", i, bus.ex_allowin); end
      checks++; if (bus.div_op !== OP_DIV) begin failures++; $display("FAIL div_wait_op cyc=%0d got=%0h exp=%0h", i, bus.div_op, OP_DIV); end
      tick();
    end
    bus.div_out_valid = 1'b1;
    bus.div_out       = 32'd14;
    #1;
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL div_pulse_allowin got=%0h exp=1", bus.ex_allowin); end
    tick();
    bus.div_out_valid = 1'b0;
    bus.ex_valid      = 1'b0;
    checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL div_mem_valid got=%0h exp=1", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'd14) begin failures++; $display("FAIL div_mem_result got=%0h exp=e", bus.mem_result); end
    checks++; if (bus.mem_pc !== 32'h200) begin failures++; $display("FAIL div_mem_pc got=%0h exp=200", bus.mem_pc); end
    checks++; if (bus.div_state !== S_IDLE) begin failures++; $display("FAIL div_state_idle got=%0h exp=%0h", bus.div_state, S_IDLE); end
    checks++; if (bus.div_busy !== 1'b0) begin failures++; $display("FAIL div_busy_clear got=%0h exp=0", bus.div_busy); end
  endtask

  task automatic test_div_hold();
    settle();
    drive_ex(OP_DIV, 1'b1, 32'h240, 32'h0, 5'd6);
    tick();
    for (int i = 1; i < 10; i++) tick();
    bus.div_out_valid = 1'b1;
    bus.div_out       = 32'd14;
    bus.mem_allowin   = 1'b0;
    tick();
    bus.div_out_valid = 1'b0;
    bus.div_out       = 32'h0;
    #1;
    checks++; if (bus.div_state !== S_DONE) begin failures++; $display("FAIL hold_state_done got=%0h exp=%0h", bus.div_state, S_DONE); end
    checks++; if (bus.div_op !== 8'h00) begin failures++; $display("FAIL hold_div_op got=%0h exp=0", bus.div_op); end
    checks++; if (bus.ex_allowin !== 1'b0) begin failures++; $display("FAIL hold_allowin got=%0h exp=0", bus.ex_allowin); end
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL hold_mem_valid got=%0h exp=0", bus.mem_valid); end
    tick();
    bus.div_out_valid = 1'b1;
    bus.div_out       = 32'hDEAD;
    tick();
    bus.div_out_valid = 1'b0;
    bus.div_out       = 32'h0;
    checks++; if (bus.div_state !== S_DONE) begin failures++; $display("FAIL hold_stray_state got=%0h exp=%0h", bus.div_state, S_DONE); end
    bus.mem_allowin = 1'b1;
    #1;
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL hold_release_allowin got=%0h exp=1", bus.ex_allowin); end
    tick();
    bus.ex_valid = 1'b0;
    checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL hold_mem_valid_out got=%0h exp=1", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'd14) begin failures++; $display("FAIL hold_mem_result got=%0h exp=e", bus.mem_result); end
    checks++; if (bus.div_state !== S_IDLE) begin failures++; $display("FAIL hold_state_idle got=%0h exp=%0h", bus.div_state, S_IDLE); end
  endtask

  task automatic test_flush_drain();
    settle();
    drive_ex(OP_DIV, 1'b1, 32'h300, 32'h0, 5'd7);
    tick();
    tick();
    tick();
    tick();
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.div_op !== 8'h00) begin failures++; $display("FAIL flush_div_op got=%0h exp=0", bus.div_op); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.div_state !== S_DRAIN) begin failures++; $display("FAIL flush_state got=%0h exp=%0h", bus.div_state, S_DRAIN); end
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL flush_mem_valid got=%0h exp=0", bus.mem_valid); end
    checks++; if (bus.div_busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%0h exp=1", bus.div_busy); end
    drive_ex(OP_ADD, 1'b0, 32'h304, 32'h55, 5'd8);
    #1;
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL drain_add_allowin got=%0h exp=1", bus.ex_allowin); end
    tick();
    checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL drain_add_valid got=%0h exp=1", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'h55) begin failures++; $display("FAIL drain_add_result got=%0h exp=55", bus.mem_result); end
    drive_ex(OP_DIVU, 1'b1, 32'h308, 32'h0, 5'd9);
    #1;
    checks++; if (bus.div_op !== 8'h00) begin failures++; $display("FAIL drain_divu_op got=%0h exp=0", bus.div_op); end
    checks++; if (bus.ex_allowin !== 1'b0) begin failures++; $display("FAIL drain_divu_allowin got=%0h exp=0", bus.ex_allowin); end
    tick();
    tick();
    bus.div_out_valid = 1'b1;
    bus.div_out       = 32'hBAD;
    #1;
    checks++; if (bus.ex_allowin !== 1'b0) begin failures++; $display("FAIL drain_pulse_allowin got=%0h exp=0", bus.ex_allowin); end
    tick();
    bus.div_out_valid = 1'b0;
    bus.div_out       = 32'h0;
    #1;
    checks++; if (bus.div_state !== S_IDLE) begin failures++; $display("FAIL drain_state_idle got=%0h exp=%0h", bus.div_state, S_IDLE); end
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL drain_discard got=%0h exp=0", bus.mem_valid); end
    checks++; if (bus.div_op !== OP_DIVU) begin failures++; $display("FAIL divu_issue_op got=%0h exp=%0h", bus.div_op, OP_DIVU); end
    tick();
    tick();
    bus.div_out_valid = 1'b1;
    bus.div_out       = 32'h21;
    tick();
    bus.div_out_valid = 1'b0;
    bus.ex_valid      = 1'b0;
    checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL divu_mem_valid got=%0h exp=1", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'h21) begin failures++; $display("FAIL divu_mem_result got=%0h exp=21", bus.mem_result); end
    checks++; if (bus.mem_op !== OP_DIVU) begin failures++; $display("FAIL divu_mem_op got=%0h exp=%0h", bus.mem_op, OP_DIVU); end
  endtask

  task automatic test_back_to_back();
    settle();
    drive_ex(OP_DIV, 1'b1, 32'h400, 32'h0, 5'd10);
    tick();
    tick();
    tick();
    bus.div_out_valid = 1'b1;
    bus.div_out       = 32'h11;
    tick();
    bus.div_out_valid = 1'b0;
    drive_ex(OP_DIV, 1'b1, 32'h404, 32'h0, 5'd11);
    #1;
    checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%0h exp=1", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'h11) begin failures++; $display("FAIL b2b_first_result got=%0h exp=11", bus.mem_result); end
    checks++; if (bus.mem_pc !== 32'h400) begin failures++; $display("FAIL b2b_first_pc got=%0h exp=400", bus.mem_pc); end
    checks++; if (bus.div_op !== OP_DIV) begin failures++; $display("FAIL b2b_second_op got=%0h exp=%0h", bus.div_op, OP_DIV); end
    tick();
    checks++; if (bus.div_state !== S_WAIT) begin failures++; $display("FAIL b2b_second_wait got=%0h exp=%0h", bus.div_state, S_WAIT); end
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL b2b_bubble got=%0h exp=0", bus.mem_valid); end
    tick();
    bus.div_out_valid = 1'b1;
    bus.div_out       = 32'h22;
    tick();
    bus.div_out_valid = 1'b0;
    bus.ex_valid      = 1'b0;
    checks++; if (bus.mem_result !== 32'h22) begin failures++; $display("FAIL b2b_second_result got=%0h exp=22", bus.mem_result); end
    checks++; if (bus.mem_pc !== 32'h404) begin failures++; $display("FAIL b2b_second_pc got=%0h exp=404", bus.mem_pc); end
  endtask

  task automatic test_reset_mid_div();
    settle();
    drive_ex(OP_DIV, 1'b1, 32'h500, 32'h0, 5'd12);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ex_valid = 1'b0;
    #1;
    checks++; if (bus.div_state !== S_IDLE) begin failures++; $display("FAIL rstmid_state got=%0h exp=%0h", bus.div_state, S_IDLE); end
    checks++; if (bus.div_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0h exp=0", bus.div_busy); end
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL rstmid_mem_valid got=%0h exp=0", bus.mem_valid); end
    checks++; if (bus.mem_result !== 32'h0) begin failures++; $display("FAIL rstmid_mem_result got=%0h exp=0", bus.mem_result); end
    checks++; if (bus.mem_pc !== 32'h0) begin failures++; $display("FAIL rstmid_mem_pc got=%0h exp=0", bus.mem_pc); end
  endtask

  task automatic test_timeout();
    settle();
    drive_ex(OP_DIV, 1'b1, 32'h600, 32'h0, 5'd13);
    tick();
    for (int i = 0; i < 60; i++) tick();
    checks++; if (bus.div_timeout !== 1'b0) begin failures++; $display("FAIL tmo_early got=%0h exp=0", bus.div_timeout); end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.div_timeout !== 1'b1) begin failures++; $display("FAIL tmo_set got=%0h exp=1", bus.div_timeout); end
    checks++; if (bus.div_state !== S_WAIT) begin failures++; $display("FAIL tmo_state got=%0h exp=%0h", bus.div_state, S_WAIT); end
    bus.div_out_valid = 1'b1;
    bus.div_out       = 32'h7;
    tick();
    bus.div_out_valid = 1'b0;
    bus.ex_valid      = 1'b0;
    tick();
    checks++; if (bus.div_timeout !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%0h exp=1", bus.div_timeout); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.div_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%0h exp=0", bus.div_timeout); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_pass();
    test_div_stall();
    test_div_hold();
    test_flush_drain();
    test_back_to_back();
    test_reset_mid_div();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
